// File: rtl/inst_encoder_loader_pkg.sv
// Shared encoder/decoder definitions: format codes, opcodes, helpers.
// IMM_RANGE_CHECK_EN enables immediate range checking in the loader.
package inst_encoder_loader_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_ISH = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4,
    FMT_U   = 3'd5,
    FMT_J   = 3'd6
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when v is a sign-extended n-bit value.
  function automatic logic fits_s(input logic [31:0] v,
                                  input int unsigned n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++)
      if (i >= int'(n) && v[i] != v[n-1]) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/inst_encoder_loader_pack.sv
// Combinational RV32I field packer: decoded fields -> instruction word.
// IMM_RANGE_CHECK_EN adds an immediate range-check output.
module inst_pack
  import inst_encoder_loader_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word
`ifdef IMM_RANGE_CHECK_EN
  ,
  output logic        imm_ok
`endif
);

  always_comb begin
    word = {funct7, rs2, rs1, funct3, rd, opcode};
    case (fmt)
      FMT_I:
        word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_ISH:
        word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      FMT_S:
        word = {imm[11:5], rs2, rs1, funct3,
                imm[4:0], opcode};
      FMT_B:
        word = {imm[12], imm[10:5], rs2, rs1, funct3,
                imm[4:1], imm[11], opcode};
      FMT_U:
        word = {imm[31:12], rd, opcode};
      FMT_J:
        word = {imm[20], imm[10:1], imm[11],
                imm[19:12], rd, opcode};
      default: ;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  always_comb begin
    imm_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S: imm_ok = fits_s(imm, 12);
      FMT_ISH:      imm_ok = ~|imm[31:5];
      FMT_B:        imm_ok = fits_s(imm, 13) & ~imm[0];
      FMT_J:        imm_ok = fits_s(imm, 21) & ~imm[0];
      FMT_U:        imm_ok = ~|imm[11:0];
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/inst_encoder_loader.sv
// Streams packed RV32I words into instruction memory at consecutive addresses.
// IMM_RANGE_CHECK_EN drops out-of-range bundles and flags imm_err.
module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              imm_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] ADDR_TOP = '1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic [31:0]       word;
  logic              imm_ok;
  logic              last_held, last_pending;
  logic              wr_fire, accept;

  inst_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .word   (word)
`ifdef IMM_RANGE_CHECK_EN
    ,
    .imm_ok (imm_ok)
`endif
  );

`ifndef IMM_RANGE_CHECK_EN
  assign imm_ok = 1'b1;
`endif

  // The held word is final if it fills DEPTH or sits at the top address.
  assign last_held    = (cnt_q == CNT_LAST) || (addr_q == ADDR_TOP);
  assign last_pending = we_q && last_held;
  assign wr_fire      = we_q && mem_ready;
  assign in_ready     = (state_q == ST_RUN) &&
                        (!we_q || mem_ready) && !last_pending;
  assign accept       = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    if (start) begin
      state_d = ST_RUN;
      addr_d  = start_addr;
      cnt_d   = '0;
      we_d    = 1'b0;
      wdata_d = '0;
      done_d  = 1'b0;
    end else begin
      if (wr_fire) begin
        we_d  = 1'b0;
        cnt_d = cnt_q + CNT_W'(1);
        if (addr_q != ADDR_TOP)
          addr_d = addr_q + ADDR_W'(1);
        if (last_held) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      if (accept && imm_ok) begin
        we_d    = 1'b1;
        wdata_d = word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (start)
      err_d = 1'b0;
    else if (accept && !imm_ok)
      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign imm_err = err_q;
`else
  assign imm_err = 1'b0;
`endif

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Inverse of the instruction decoder: it packs decoded RV32I fields (format, opcode, funct3/funct7, rd, rs1, rs2, immediate) into 32-bit instruction words.
- It streams those words into instruction memory at consecutive word addresses.
- Used by the bench/boot path to build programs in-system without a pre-assembled hex file.
- Valid/ready input side, one registered output stage with memory back-pressure, and an address counter with a run/done state machine.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address.
- DEPTH, 256, number of words writable before done; requires DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; (re)starts loading at start_addr.
- start_addr  in  ADDR_W  first word address.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  bundle accepted when in_valid && in_ready.
- in_fmt  in  3  FMT_R/FMT_I/FMT_ISH/FMT_S/FMT_B/FMT_U/FMT_J.
- in_opcode  in  7  opcode field.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R, ISH only).
- in_rd  in  5  destination register.
- in_rs1  in  5  first source register.
- in_rs2  in  5  second source register.
- in_imm  in  32  immediate, byte-offset value as the decoder reports it.
- mem_we  out  1  write request (output word valid).
- mem_ready  in  1  memory accepts write this cycle.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- busy  out  1  state RUN.
- done  out  1  DEPTH words written or top address reached; sticky until start.
- imm_err  out  1  sticky immediate-range error (feature only).

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, imm_err=0. State IDLE, word count 0.
- States:
  - IDLE --start--> RUN: addr<=start_addr, count<=0, output stage cleared.
  - RUN --last write accepted--> DONE.
  - DONE --start--> RUN.
  - start in RUN restarts immediately: pending output word discarded, addr reloaded, done cleared.
- in_ready = (state==RUN) && (!mem_we || mem_ready) && !last_pending, where last_pending = mem_we while the held word is the final one (count==DEPTH-1 or addr==2**ADDR_W-1).
- Latency: bundle accepted in cycle N -> mem_we=1 with the encoded word in cycle N+1. Back-to-back throughput is 1 word/cycle while mem_ready=1.
- mem_we/mem_addr/mem_wdata are held stable while mem_ready=0.
- On mem_we && mem_ready: addr+1, count+1. If that was the final word, the next state is DONE and done=1 next cycle. Address never wraps.
- Encoding, bits 31..0:
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - ISH: funct7, imm[4:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
- Unused fields are ignored. Undefined in_fmt encodes as R.
- Out-of-range immediates are truncated to the bit slices listed.
- Reset mid-operation: everything returns to reset values. A write in flight is abandoned.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- When defined, on acceptance the block checks:
  - I/S: in_imm within the signed 12-bit range.
  - ISH: in_imm[31:5]==0.
  - B: signed 13-bit and imm[0]==0.
  - J: signed 21-bit and imm[0]==0.
  - U: imm[11:0]==0.
- A failing bundle is consumed but not written; address and count do not advance, and imm_err sets. imm_err clears only on start or rst.
- When not defined: no check, imm_err tied 0, every accepted bundle is written.

Decomposition:
- Add FMT_* codes (3-bit) and the opcode constants to the shared macro.vh, alongside the existing opcode macros, so the encoder and decoder share one definition.
- One natural sub-module: inst_pack, purely combinational fields -> 32-bit word (plus range-check output under the macro).
- The wrapper owns the FSM, address counter and output register.

Test Plan:
- start, start_addr=0x10. Send I addi rd=1 rs1=0 f3=0 op=0x13 imm=5 -> next cycle mem_we=1, mem_addr=0x10, mem_wdata=0x00500093.
- Back-to-back S sw rs2=2 rs1=1 f3=2 op=0x23 imm=8, then B beq rs1=1 rs2=2 imm=-4 op=0x63 -> 0x0020A423 @addr N, 0xFE208EE3 @addr N+1, one per cycle.
- J jal rd=1 imm=8 op=0x6F -> 0x008000EF. U lui rd=5 imm=0x12345000 op=0x37 -> 0x123452B7.
- Hold mem_ready=0 for 3 cycles with a word pending -> in_ready=0, outputs stable, address unchanged; on release the word is written once and the address increments once.
- DEPTH=4, start_addr=0, send 5 bundles -> 4 writes (addr 0..3), done=1, fifth never accepted. Start pulse -> busy=1, done=0, address reloaded.
- IMM_RANGE_CHECK_EN: I imm=4096 -> no write, imm_err=1. Next valid bundle writes at the unchanged address. Async rst mid-RUN -> all outputs at reset values within the same cycle.
